reg_scoreboard: RTL and testbench

//  Dual-issue register scoreboard at the issue/exe0 boundary; producer-side

---
 rtl/reg_scoreboard.sv | 98 +++++++++
 tb/tb_reg_scoreboard.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Dual-issue GPR scoreboard: per-register countdown until the in-flight result is
// forwardable; gates issue of each slot on operand availability and WAW hazards.
module reg_scoreboard #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             hold,
    input  logic             valid0,
    input  logic             valid1,
    input  logic [4:0]       rj0,
    input  logic [4:0]       rj1,
    input  logic [4:0]       rk0,
    input  logic [4:0]       rk1,
    input  logic [4:0]       rd0,
    input  logic [4:0]       rd1,
    input  logic             rd_rd0,
    input  logic             rd_rd1,
    input  logic             we0,
    input  logic             we1,
    input  logic [CNT_W-1:0] lat0,
    input  logic [CNT_W-1:0] lat1,
    input  logic             done_v,
    input  logic [4:0]       done_rd,
    output logic             ready0,
    output logic             ready1,
    output logic [NREG-1:0]  busy_vec
);

    localparam logic [CNT_W-1:0] LONG = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    logic ok0, ok1, pair_raw;

    function automatic logic src_busy(input logic [4:0] r);
        return (r != 5'd0) && (cnt_q[r] != '0);
    endfunction

    function automatic logic waw_long(input logic we, input logic [4:0] r);
        return we && (r != 5'd0) && (cnt_q[r] == LONG);
    endfunction

    always_comb begin
        ok0 = valid0 & ~src_busy(rj0) & ~src_busy(rk0) & ~(rd_rd0 & src_busy(rd0))
              & ~waw_long(we0, rd0);
        ok1 = valid1 & ~src_busy(rj1) & ~src_busy(rk1) & ~(rd_rd1 & src_busy(rd1))
              & ~waw_long(we1, rd1);
        // Slot1 cannot take slot0's result in the same cycle unless it is ready next cycle.
        pair_raw = we0 & (rd0 != 5'd0) & (lat0 != '0)
                   & ((rj1 == rd0) | (rk1 == rd0) | (rd_rd1 & (rd1 == rd0)));
        ready0 = rstn & ~hold & ~flush & ok0;
        ready1 = ready0 & ok1 & ~pair_raw;
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_vec[r] = (cnt_q[r] != '0);
        end
    end

    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (ready1 && we1 && (rd1 == 5'(r))) begin
                cnt_d[r] = lat1;
            end else if (ready0 && we0 && (rd0 == 5'(r))) begin
                cnt_d[r] = lat0;
            end else if (done_v && (done_rd == 5'(r)) && (cnt_q[r] == LONG)) begin
                cnt_d[r] = '0;
            end else if (cnt_q[r] == LONG) begin
                cnt_d[r] = cnt_q[r];
            end else if ((cnt_q[r] != '0) && !hold) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, random stimulus
// against a rule-level reference model, and reset corner cases.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rstn, flush, hold, valid0, valid1;
    logic [4:0]  rj0, rj1, rk0, rk1, rd0, rd1, done_rd;
    logic        rd_rd0, rd_rd1, we0, we1, done_v;
    logic [2:0]  lat0, lat1;
    logic        ready0, ready1;
    logic [31:0] busy_vec;

    int checks = 0;
    int failures = 0;

    reg_scoreboard dut (
        .clk(clk), .rstn(rstn), .flush(flush), .hold(hold),
        .valid0(valid0), .valid1(valid1),
        .rj0(rj0), .rj1(rj1), .rk0(rk0), .rk1(rk1), .rd0(rd0), .rd1(rd1),
        .rd_rd0(rd_rd0), .rd_rd1(rd_rd1), .we0(we0), .we1(we1),
        .lat0(lat0), .lat1(lat1), .done_v(done_v), .done_rd(done_rd),
        .ready0(ready0), .ready1(ready1), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v0; logic [4:0] j0, k0, d0; logic rr0, w0; logic [2:0] l0;
        logic v1; logic [4:0] j1, k1, d1; logic w1; logic [2:0] l1;
        logic h, f, dv; logic [4:0] dr;
        logic e0, e1; logic [31:0] eb;
    } vec_t;

    vec_t tbl[$];

    // Reference model: remaining cycles per register, LONG (7) = waiting on done_v.
    int mcnt[32];

    function automatic vec_t mk(
        input logic v0, input logic [4:0] j0, k0, d0, input logic rr0, w0,
        input logic [2:0] l0,
        input logic v1, input logic [4:0] j1, k1, d1, input logic w1,
        input logic [2:0] l1,
        input logic h, f, dv, input logic [4:0] dr,
        input logic e0, e1, input logic [31:0] eb);
        vec_t t;
        t.v0 = v0; t.j0 = j0; t.k0 = k0; t.d0 = d0; t.rr0 = rr0; t.w0 = w0; t.l0 = l0;
        t.v1 = v1; t.j1 = j1; t.k1 = k1; t.d1 = d1; t.w1 = w1; t.l1 = l1;
        t.h = h; t.f = f; t.dv = dv; t.dr = dr; t.e0 = e0; t.e1 = e1; t.eb = eb;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        valid0 = t.v0; rj0 = t.j0; rk0 = t.k0; rd0 = t.d0; rd_rd0 = t.rr0;
        we0 = t.w0; lat0 = t.l0;
        valid1 = t.v1; rj1 = t.j1; rk1 = t.k1; rd1 = t.d1; rd_rd1 = 1'b0;
        we1 = t.w1; lat1 = t.l1;
        hold = t.h; flush = t.f; done_v = t.dv; done_rd = t.dr;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic mbusy(input logic [4:0] r);
        return (r != 0) && (mcnt[r] != 0);
    endfunction

    function automatic logic slot_ok(input logic v, input logic [4:0] j, k, d,
                                     input logic rr, w);
        logic [4:0] srcs[$];
        srcs.push_back(j);
        srcs.push_back(k);
        if (rr) srcs.push_back(d);
        if (!v) return 1'b0;
        foreach (srcs[i]) if (mbusy(srcs[i])) return 1'b0;
        if (w && d != 0 && mcnt[d] == 7) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_exp(output logic e0, output logic e1, output logic [31:0] eb);
        logic dep;
        e0 = rstn && !hold && !flush && slot_ok(valid0, rj0, rk0, rd0, rd_rd0, we0);
        dep = we0 && rd0 != 0 && lat0 != 0 &&
              (rj1 == rd0 || rk1 == rd0 || (rd_rd1 && rd1 == rd0));
        e1 = e0 && slot_ok(valid1, rj1, rk1, rd1, rd_rd1, we1) && !dep;
        eb = '0;
        for (int r = 1; r < 32; r++) eb[r] = (mcnt[r] != 0);
    endtask

    task automatic model_update(input logic f0, input logic f1);
        int n[32];
        for (int r = 1; r < 32; r++) begin
            n[r] = mcnt[r];
            if (flush) n[r] = 0;
            else if (f1 && we1 && rd1 == r) n[r] = int'(lat1);
            else if (f0 && we0 && rd0 == r) n[r] = int'(lat0);
            else if (done_v && done_rd == r && mcnt[r] == 7) n[r] = 0;
            else if (mcnt[r] == 7) n[r] = 7;
            else if (mcnt[r] > 0 && !hold) n[r] = mcnt[r] - 1;
        end
        for (int r = 1; r < 32; r++) mcnt[r] = n[r];
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
    endtask

    function automatic logic [2:0] rand_lat();
        int s;
        s = int'($urandom_range(0, 5));
        case (s)
            0: return 3'd0;
            1: return 3'd1;
            2: return 3'd2;
            3: return 3'd3;
            default: return (($urandom_range(0, 2) == 0) ? 3'd7 : 3'd1);
        endcase
    endfunction

    initial begin
        logic e0, e1;
        logic [31:0] eb;

        rstn = 1'b0;
        apply(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 0,0,0));
        model_clear();

        // c0-c2 load-use
        tbl.push_back(mk(1,0,0,5,0,1,1,  0,0,0,0,0,0, 0,0,0,0, 1,0,32'h0));
        tbl.push_back(mk(1,5,0,10,0,1,0, 0,0,0,0,0,0, 0,0,0,0, 0,0,32'h20));
        tbl.push_back(mk(1,5,0,10,0,1,0, 0,0,0,0,0,0, 0,0,0,0, 1,0,32'h0));
        // c3-c5 intra-pair RAW
        tbl.push_back(mk(1,0,0,3,0,1,1,  1,0,3,0,0,0, 0,0,0,0, 1,0,32'h0));
        tbl.push_back(mk(1,0,0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0, 1,0,32'h8));
        tbl.push_back(mk(1,0,0,3,0,1,0,  1,0,3,0,0,0, 0,0,0,0, 1,1,32'h0));
        // c6-c15 hold freezes a finite counter
        tbl.push_back(mk(1,0,0,4,0,1,3,  0,0,0,0,0,0, 0,0,0,0, 1,0,32'h0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0, 1,0,0,0, 0,0,32'h10));
        tbl.push_back(mk(1,4,0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0, 0,0,32'h10));
        tbl.push_back(mk(1,0,0,4,1,0,0,  0,0,0,0,0,0, 0,0,0,0, 0,0,32'h10));
        tbl.push_back(mk(1,4,0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0, 0,0,32'h10));
        tbl.push_back(mk(1,4,0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0, 1,0,32'h0));
        // c16-c18 flush clears finite and LONG counters
        tbl.push_back(mk(1,0,0,2,0,1,3,  1,0,0,9,1,7, 0,0,0,0, 1,1,32'h0));
        tbl.push_back(mk(1,0,0,0,0,0,0,  0,0,0,0,0,0, 0,1,0,0, 0,0,32'h204));
        tbl.push_back(mk(0,0,0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0, 0,0,32'h0));
        // c19-c21 WAW pair: younger latency wins
        tbl.push_back(mk(1,0,0,6,0,1,3,  1,0,0,6,1,1, 0,0,0,0, 1,1,32'h0));
        tbl.push_back(mk(0,0,0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0, 0,0,32'h40));
        tbl.push_back(mk(0,0,0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0, 0,0,32'h0));
        // c22-c35 divider: LONG survives hold, WAW stalls, done_v frees
        tbl.push_back(mk(1,0,0,7,0,1,7,  0,0,0,0,0,0, 0,0,0,0, 1,0,32'h0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1,7,0,0,0,0,0, 0,0,0,0,0,0, 1'(i % 2),0,0,0, 0,0,32'h80));
        tbl.push_back(mk(1,0,0,7,0,1,1,  0,0,0,0,0,0, 0,0,0,0, 0,0,32'h80));
        tbl.push_back(mk(1,7,0,0,0,0,0,  0,0,0,0,0,0, 0,0,1,7, 0,0,32'h80));
        tbl.push_back(mk(1,7,0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0, 1,0,32'h0));
        // c36-c37 r0 writes never tracked
        tbl.push_back(mk(1,0,0,0,0,1,7,  1,0,0,0,1,7, 0,0,0,0, 1,1,32'h0));
        tbl.push_back(mk(1,0,0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0, 1,0,32'h0));
        // c38-c41 done_v on a finite counter is ignored
        tbl.push_back(mk(1,0,0,11,0,1,2, 0,0,0,0,0,0, 0,0,0,0, 1,0,32'h0));
        tbl.push_back(mk(0,0,0,0,0,0,0,  0,0,0,0,0,0, 0,0,1,11, 0,0,32'h800));
        tbl.push_back(mk(0,0,0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0, 0,0,32'h800));
        tbl.push_back(mk(0,0,0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0, 0,0,32'h0));

        #3;
        chk("reset_ready0", 32'(ready0), 32'h0);
        chk("reset_busy", busy_vec, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("release_ready0", 32'(ready0), 32'h1);
        @(negedge clk);

        foreach (tbl[i]) begin
            apply(tbl[i]);
            #1;
            model_exp(e0, e1, eb);
            chk($sformatf("tbl%0d_ready0", i), 32'(ready0), 32'(tbl[i].e0));
            chk($sformatf("tbl%0d_ready1", i), 32'(ready1), 32'(tbl[i].e1));
            chk($sformatf("tbl%0d_busy", i), busy_vec, tbl[i].eb);
            @(posedge clk);
            model_update(e0, e1);
            @(negedge clk);
        end

        for (int c = 0; c < 3000; c++) begin
            valid0 = ($urandom_range(0, 9) < 8); valid1 = ($urandom_range(0, 9) < 7);
            rj0 = 5'($urandom_range(0, 7)); rk0 = 5'($urandom_range(0, 7));
            rd0 = 5'($urandom_range(0, 7)); rj1 = 5'($urandom_range(0, 7));
            rk1 = 5'($urandom_range(0, 7)); rd1 = 5'($urandom_range(0, 7));
            rd_rd0 = ($urandom_range(0, 3) == 0); rd_rd1 = ($urandom_range(0, 3) == 0);
            we0 = ($urandom_range(0, 3) != 0); we1 = ($urandom_range(0, 3) != 0);
            lat0 = rand_lat(); lat1 = rand_lat();
            hold = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 39) == 0);
            done_v = ($urandom_range(0, 3) == 0); done_rd = 5'($urandom_range(0, 7));
            #1;
            model_exp(e0, e1, eb);
            chk("rand_ready0", 32'(ready0), 32'(e0));
            chk("rand_ready1", 32'(ready1), 32'(e1));
            chk("rand_busy", busy_vec, eb);
            @(posedge clk);
            model_update(e0, e1);
            @(negedge clk);
        end

        // Asynchronous reset between edges clears counters at once.
        apply(mk(1,0,0,5,0,1,7, 1,0,0,12,1,3, 0,0,0,0, 0,0,0));
        @(posedge clk);
        @(negedge clk);
        apply(mk(1,5,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 0,0,0));
        #1;
        chk("pre_async_busy", 32'(busy_vec[5]), 32'h1);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_busy", busy_vec, 32'h0);
        chk("async_ready0", 32'(ready0), 32'h0);
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_async_ready0", 32'(ready0), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
